// File: rtl/sar_search_ctrl_pkg.sv
// rtl/sar_search_ctrl_pkg.sv - shared types and constants for the SAR search controller
// Purpose: FSM state encoding, default search width and derived bit-index width.
// Ports: none (package).
// Optional feature macro used elsewhere in this slice: SAR_INT_CMP_EN.
package sar_search_pkg;

  localparam int unsigned SAR_DATA_WIDTH = 13;
  localparam int unsigned SAR_IDX_W      = $clog2(SAR_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_search_ctrl_if.sv
// rtl/sar_search_ctrl_if.sv - request/answer interface of the SAR search controller
// Purpose: bundles start, comparison answer, trial value and result signals.
// Signals: start_i (start request), lt_i (target < cand_o answer) or, with
//   SAR_INT_CMP_EN defined, ref_i (value searched for by the internal comparator),
//   cand_o (trial value), busy_o, done_o (one-cycle), result_o (resolved value).
// Modports: master = the controller, slave = the requesting/comparing side.
interface sar_search_ctrl_if
  import sar_search_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAR_DATA_WIDTH
);

  logic                  start_i;
`ifdef SAR_INT_CMP_EN
  logic [DATA_WIDTH-1:0] ref_i;
`else
  logic                  lt_i;
`endif
  logic [DATA_WIDTH-1:0] cand_o;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

`ifdef SAR_INT_CMP_EN
  modport master (input start_i, input ref_i, output cand_o, output busy_o,
                  output done_o, output result_o);
  modport slave  (output start_i, output ref_i, input cand_o, input busy_o,
                  input done_o, input result_o);
`else
  modport master (input start_i, input lt_i, output cand_o, output busy_o,
                  output done_o, output result_o);
  modport slave  (output start_i, output lt_i, input cand_o, input busy_o,
                  input done_o, input result_o);
`endif

endinterface

// File: rtl/sar_search_ctrl_cmp.sv
// rtl/sar_search_ctrl_cmp.sv - unsigned less-than comparator used by the internal-compare build
// Purpose: lt_o = (A_i < B_i), unsigned, purely combinational.
// Ports: A_i [WIDTH-1:0], B_i [WIDTH-1:0], lt_o.
// Only present when SAR_INT_CMP_EN is defined.
`ifdef SAR_INT_CMP_EN
module comparatorLessThan #(
  parameter int unsigned WIDTH = 13
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             lt_o
);

  assign lt_o = (A_i < B_i);

endmodule
`endif

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation (bisection) search controller
// Purpose: resolves, MSB first, the largest X whose "target < X" answer is 0,
//   trying one bit per cycle over DATA_WIDTH cycles.
// Ports: clk_i, rst_n_i (async active-low), bus (sar_search_ctrl_if.master):
//   start_i, lt_i / ref_i, cand_o, busy_o, done_o, result_o.
// Macro SAR_INT_CMP_EN: replaces lt_i with ref_i and an internal comparatorLessThan.
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAR_DATA_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  sar_search_ctrl_if.master   bus
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [IDX_W-1:0]      idx_t;

  localparam idx_t  IDX_MSB = idx_t'(DATA_WIDTH - 1);
  localparam word_t ONE     = word_t'(1);

  sar_state_e state_q, state_d;
  idx_t       idx_q,    idx_d;
  word_t      cand_q,   cand_d;
  word_t      result_q, result_d;
  word_t      acc_upd;
  logic       lt;

`ifdef SAR_INT_CMP_EN
  comparatorLessThan #(
    .WIDTH (DATA_WIDTH)
  ) u_cmp (
    .A_i  (bus.ref_i),
    .B_i  (cand_q),
    .lt_o (lt)
  );
`else
  assign lt = bus.lt_i;
`endif

  // cand_q doubles as the accumulator: bits above idx are decided, bit idx
  // is the trial bit, bits below are zero.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    result_d = result_q;
    acc_upd  = cand_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = TEST;
          idx_d   = IDX_MSB;
          cand_d  = ONE << IDX_MSB;
        end
      end
      TEST: begin
        // lt is looked at only here so an undriven answer elsewhere is harmless
        if (lt) begin
          acc_upd = cand_q & ~(ONE << idx_q);
        end
        if (idx_q != '0) begin
          idx_d  = idx_q - idx_t'(1);
          cand_d = acc_upd | (ONE << (idx_q - idx_t'(1)));
        end else begin
          result_d = acc_upd;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      idx_q    <= IDX_MSB;
      cand_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      result_q <= result_d;
    end
  end

  assign bus.cand_o   = cand_q;
  assign bus.result_o = result_q;
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = (state_q == DONE);

endmodule
